// File: rtl/lzc_normalizer_pipe.sv
// Two-stage FP normaliser: leading-zero count, left shift, exponent adjust with denormal clamp.
// Latency 2 cycles, 1 beat/cycle; in_ready falls only when both stages hold data and out_ready is low.
module lzc_normalizer_pipe #(
   parameter  int WIDTH     = 27,
   parameter  int EXP_WIDTH = 8,
   parameter  int TAG_WIDTH = 4,
   localparam int SW        = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_mant,
   input  logic [EXP_WIDTH-1:0] in_exp,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_mant,
   output logic [EXP_WIDTH-1:0] out_exp,
   output logic [SW-1:0]        out_shift,
   output logic                 out_zero,
   output logic                 out_denorm,
   output logic [TAG_WIDTH-1:0] out_tag
);

   // Wide enough that neither the exponent nor the count is truncated in the compare.
   localparam int CW = ((SW > EXP_WIDTH) ? SW : EXP_WIDTH) + 1;

   logic                 s1_valid;
   logic [WIDTH-1:0]     s1_mant;
   logic [EXP_WIDTH-1:0] s1_exp;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic [SW-1:0]        s1_lz;

   logic                 s2_adv;
   logic [SW-1:0]        in_lz;

   logic [CW-1:0]        exp_c;
   logic [CW-1:0]        lz_c;
   logic [WIDTH-1:0]     nxt_mant;
   logic [EXP_WIDTH-1:0] nxt_exp;
   logic [SW-1:0]        nxt_shift;
   logic                 nxt_zero;
   logic                 nxt_denorm;

   assign s2_adv   = ~out_valid | out_ready;
   assign in_ready = ~s1_valid | s2_adv;

   // Scanning upward lets the highest set bit win; an all-zero word leaves WIDTH.
   always_comb begin
      in_lz = SW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (in_mant[i]) begin
            in_lz = SW'(WIDTH - 1 - i);
         end
      end
   end

   always_comb begin
      exp_c      = CW'(s1_exp);
      lz_c       = CW'(s1_lz);
      nxt_exp    = '0;
      nxt_shift  = '0;
      nxt_zero   = 1'b0;
      nxt_denorm = 1'b0;
      if (s1_mant == '0) begin
         nxt_zero = 1'b1;
      end else if (exp_c > lz_c) begin
         nxt_shift = s1_lz;
         nxt_exp   = EXP_WIDTH'(exp_c - lz_c);
      end else begin
         // exp <= lz <= WIDTH here, so exp-1 always fits the shift field.
         nxt_shift  = (s1_exp == '0) ? '0 : SW'(exp_c - CW'(1));
         nxt_denorm = 1'b1;
      end
      nxt_mant = s1_mant << nxt_shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_mant    <= '0;
         s1_exp     <= '0;
         s1_tag     <= '0;
         s1_lz      <= '0;
         out_valid  <= 1'b0;
         out_mant   <= '0;
         out_exp    <= '0;
         out_shift  <= '0;
         out_zero   <= 1'b0;
         out_denorm <= 1'b0;
         out_tag    <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_mant <= in_mant;
               s1_exp  <= in_exp;
               s1_tag  <= in_tag;
               s1_lz   <= in_lz;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_mant   <= nxt_mant;
               out_exp    <= nxt_exp;
               out_shift  <= nxt_shift;
               out_zero   <= nxt_zero;
               out_denorm <= nxt_denorm;
               out_tag    <= s1_tag;
            end
         end
      end
   end

endmodule

// File: doc/lzc_normalizer_pipe.md
Name: lzc_normalizer_pipe

Overview:
- Parametrised, pipelined normaliser for the FP add/sub datapath.
- Counts leading zeros of an unnormalised mantissa, left-shifts it to normalise, and adjusts the biased exponent.
- Clamps the shift at the denormal boundary and flags zero and denormal results.
- Sits between the mantissa subtractor and the rounding stage, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 27, mantissa width incl. guard/round/sticky; bit WIDTH-1 is the hidden-bit position.
- EXP_WIDTH, 8, biased exponent width.
- TAG_WIDTH, 4, opaque sideband carried alongside the data (op id, sign, etc.).
- SW (localparam), $clog2(WIDTH+1), shift-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mant  in  WIDTH  unnormalised mantissa.
- in_exp  in  EXP_WIDTH  biased exponent of in_mant[WIDTH-1].
- in_tag  in  TAG_WIDTH  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mant  out  WIDTH  normalised mantissa.
- out_exp  out  EXP_WIDTH  adjusted exponent.
- out_shift  out  SW  left-shift amount applied.
- out_zero  out  1  input mantissa was all zeros.
- out_denorm  out  1  result is denormal: shift clamped, out_exp = 0.
- out_tag  out  TAG_WIDTH  in_tag, delayed.

Behaviour:
- Two-stage pipeline; latency exactly 2 cycles from accepted input to out_valid with no backpressure.
- Throughput is 1 beat/cycle.
- Stage 1 (S1):
  - Registers mant/exp/tag on acceptance (in_valid & in_ready).
  - Computes lz = number of leading zeros of mant, range 0..WIDTH, for any WIDTH (no fixed-width case table).
  - Registers lz.
- Stage 2 (S2) computes from S1 registers and registers outputs:
  - mant == 0: out_zero=1, out_mant=0, out_exp=0, out_shift=0, out_denorm=0.
  - exp > lz: out_shift=lz, out_exp=exp-lz, out_mant=mant<<lz (MSB set), out_denorm=0.
  - exp <= lz, mant != 0: out_shift = (exp==0) ? 0 : exp-1; out_exp=0; out_mant=mant<<out_shift; out_denorm=1.
- Comparisons are unsigned; the lz/exp comparison is done at max(SW, EXP_WIDTH)+1 bits, with no truncation.
- Shifting is logical: zeros enter at the LSB.
- Handshake:
  - s2_adv = ~s2_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv (combinational).
  - S1 loads when in_ready; S2 loads when s2_adv.
  - Output regs hold stable while out_valid & ~out_ready.
- Full pipeline with out_ready=0: in_ready=0. Exactly 2 beats are buffered; none dropped or duplicated; order preserved.
- Simultaneous drain and fill: with out_ready=1 and in_valid=1 on a full pipe, one beat exits and one enters in the same cycle.
- in_valid=0: bubbles propagate. out_valid drops when S2 drains with no replacement.
- Reset:
  - s1_valid, s2_valid, out_valid = 0; all out_* data regs = 0.
  - in_ready = 1 in the cycle after rst deasserts.
  - rst mid-operation discards in-flight beats; no partial result is emitted.
- rst and in_valid asserted together: the beat is not accepted.

Test Plan:
- WIDTH=27, EXP_WIDTH=8. in_mant=27'h0400000, in_exp=100 -> after 2 cycles: out_mant=27'h4000000, out_exp=96, out_shift=4, out_zero=0, out_denorm=0.
- Boundary sweep on in_mant=27'h0400000 (lz=4):
  - in_exp=5 -> out_exp=1, out_shift=4, out_denorm=0.
  - in_exp=4 -> out_shift=3, out_exp=0, out_mant=27'h2000000, out_denorm=1.
  - in_exp=0 -> out_shift=0, out_mant=27'h0400000, out_denorm=1.
- in_mant=27'h0000001, in_exp=10 -> out_shift=9, out_mant=27'h0000200, out_exp=0, out_denorm=1. in_mant=0, in_exp=50 -> out_zero=1, out_mant=0, out_exp=0, out_shift=0.
- Backpressure:
  - Hold out_ready=0 and drive 3 beats with tags 1,2,3 -> in_ready=0 after tags 1,2 are accepted; tag 3 stalls; out_* stable.
  - Then release out_ready=1 -> tags 1,2,3 emerge on consecutive cycles in order.
- Streaming: 100 random back-to-back beats with out_ready=1 -> in_ready constantly 1, out_valid continuous from cycle 2, every result matches the reference model.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all outputs 0 next cycle; neither beat ever appears; a fresh beat afterwards returns after 2 cycles.
- Re-run the sweep with WIDTH=53, EXP_WIDTH=11: in_mant=1, in_exp=2000 -> out_shift=52, out_exp=1948.
